// File: rtl/register_access_bridge.sv
// ---------------------------------------------------------------------------
// register_access_bridge
//
// Master-side bridge between a valid/ready request/response channel and a
// simple register-block bus (address / write_enable / write_data /
// read_enable / read_data). It handles one transaction at a time.
//
// Each transaction runs in this order:
//   - Accept edge: the request is latched onto the bus registers.
//   - Setup cycle: address and write_data are driven and already stable.
//   - Strobe cycle: write_enable or read_enable is high for exactly one cycle.
//     read_data is captured at the end of this cycle.
//   - Response: rsp_valid is held until rsp_ready is seen.
//
// The setup cycle means the bus address is stable for a full cycle before
// the strobe. This gives the edge spacing
//   handshake N -> strobe N+1 -> rsp_valid N+2 -> completion N+3.
//
// Configuration macro: REG_BRIDGE_WRITE_ACK_EN
//   - defined:   writes also return a response (rsp_write=1, rsp_rdata=0).
//   - undefined: writes return straight to IDLE and only reads respond.
//
// All outputs are registered. Reset is synchronous and active-low.
// ---------------------------------------------------------------------------
module register_access_bridge #(
  parameter int ADDR_WIDTH  = 33,
  parameter int WDATA_WIDTH = 33,
  parameter int RDATA_WIDTH = 21
) (
  input  logic                   clock,
  input  logic                   reset,
  // request channel
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_write,
  input  logic [ADDR_WIDTH-1:0]  req_addr,
  input  logic [WDATA_WIDTH-1:0] req_wdata,
  // response channel
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic                   rsp_write,
  output logic [RDATA_WIDTH-1:0] rsp_rdata,
  // register-block bus
  output logic [ADDR_WIDTH-1:0]  address,
  output logic                   write_enable,
  output logic [WDATA_WIDTH-1:0] write_data,
  output logic                   read_enable,
  input  logic [RDATA_WIDTH-1:0] read_data
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t                 state_q;
  logic                   req_ready_q;
  logic                   rsp_valid_q;
  logic                   rsp_write_q;
  logic [RDATA_WIDTH-1:0] rsp_rdata_q;
  logic [ADDR_WIDTH-1:0]  address_q;
  logic [WDATA_WIDTH-1:0] write_data_q;
  logic                   write_enable_q;
  logic                   read_enable_q;

  // A strobe is already high exactly when ACCESS is in its strobe cycle.
  logic strobe_active;
  assign strobe_active = write_enable_q | read_enable_q;

  // Transaction sequencer; every output is a register updated here.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q        <= IDLE;
      req_ready_q    <= 1'b1;
      rsp_valid_q    <= 1'b0;
      rsp_write_q    <= 1'b0;
      rsp_rdata_q    <= '0;
      address_q      <= '0;
      write_data_q   <= '0;
      write_enable_q <= 1'b0;
      read_enable_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          // req_ready_q is high throughout IDLE, so req_valid is the handshake.
          if (req_valid && req_ready_q) begin
            address_q   <= req_addr;
            rsp_write_q <= req_write;
            // Reads leave write_data untouched on the bus.
            if (req_write) begin
              write_data_q <= req_wdata;
            end
            req_ready_q <= 1'b0;
            state_q     <= ACCESS;
          end
        end

        ACCESS: begin
          if (!strobe_active) begin
            // Setup cycle done: raise exactly one strobe for one cycle.
            write_enable_q <= rsp_write_q;
            read_enable_q  <= ~rsp_write_q;
          end else begin
            // Strobe cycle done: drop the strobe and capture the result.
            write_enable_q <= 1'b0;
            read_enable_q  <= 1'b0;
            if (rsp_write_q) begin
              rsp_rdata_q <= '0;
`ifdef REG_BRIDGE_WRITE_ACK_EN
              rsp_valid_q <= 1'b1;
              state_q     <= RESP;
`else
              // Fire-and-forget write: no response, ready for the next request.
              req_ready_q <= 1'b1;
              state_q     <= IDLE;
`endif
            end else begin
              rsp_rdata_q <= read_data;
              rsp_valid_q <= 1'b1;
              state_q     <= RESP;
            end
          end
        end

        RESP: begin
          // Hold rsp_rdata and rsp_write until the consumer takes them.
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign req_ready    = req_ready_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_write    = rsp_write_q;
  assign rsp_rdata    = rsp_rdata_q;
  assign address      = address_q;
  assign write_data   = write_data_q;
  assign write_enable = write_enable_q;
  assign read_enable  = read_enable_q;

endmodule

// File: tb/tb_register_access_bridge.sv
// ---------------------------------------------------------------------------
// Testbench for register_access_bridge.
//
// The bench contains a small register block with 8 entries, selected by
// address[2:0]. That block answers read_data combinationally.
//
// The reference model is a transaction-level array of the last data written
// to each entry. Expected timing is counted in edges from each handshake.
// ---------------------------------------------------------------------------
module tb_register_access_bridge;

  localparam int AW = 33;
  localparam int WW = 33;
  localparam int RW = 21;

`ifdef REG_BRIDGE_WRITE_ACK_EN
  localparam bit ACK = 1'b1;
`else
  localparam bit ACK = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [WW-1:0] req_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic          rsp_write;
  logic [RW-1:0] rsp_rdata;
  logic [AW-1:0] address;
  logic          write_enable;
  logic [WW-1:0] write_data;
  logic          read_enable;
  logic [RW-1:0] read_data;

  register_access_bridge #(
    .ADDR_WIDTH (AW),
    .WDATA_WIDTH(WW),
    .RDATA_WIDTH(RW)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_write   (rsp_write),
    .rsp_rdata   (rsp_rdata),
    .address     (address),
    .write_enable(write_enable),
    .write_data  (write_data),
    .read_enable (read_enable),
    .read_data   (read_data)
  );

  always #5 clock = ~clock;

  // Register-block model: the environment, not the reference.
  logic [RW-1:0] blk_mem [8] = '{default: '0};
  assign read_data = blk_mem[address[2:0]];
  always @(posedge clock) begin
    if (write_enable) blk_mem[address[2:0]] <= write_data[RW-1:0];
  end

  // Edge and strobe counters.
  int cyc    = 0;
  int we_cnt = 0;
  int re_cnt = 0;
  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (write_enable) we_cnt <= we_cnt + 1;
    if (read_enable)  re_cnt <= re_cnt + 1;
  end

  int vectors     = 0;
  int miscompares = 0;

  // Strobes must never overlap.
  always @(negedge clock) begin
    vectors++;
    assert (!(write_enable && read_enable)) else begin
      miscompares++;
      $error("FAIL strobe_overlap: observed we=%0b re=%0b required not both", write_enable, read_enable);
    end
  end

  // Watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, required finish before 200000");
    $fatal(1, "timeout");
  end

  // Reference model state.
  logic [AW-1:0] addr_tab [8];
  logic [RW-1:0] exp_mem  [8];
  logic [WW-1:0] last_wd;
  int            hs_cyc;
  int            prev_hs;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 'h%0h required 'h%0h", tag, obs, exp);
    end
  endtask

  task automatic do_txn(input bit wr, input int idx, input logic [WW-1:0] wd,
                        input int hold, input bit offer);
    int            n;
    int            we0;
    int            re0;
    bit            exp_rsp;
    logic [RW-1:0] exp_rd;
    logic [63:0]   junk;

    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr_tab[idx];
    req_wdata = wd;
    rsp_ready = (hold == 0);

    n = 0;
    while (!req_ready && n < 50) begin
      tick();
      n++;
    end
    chk("req_ready_wait", 64'(req_ready), 64'(1));

    we0 = we_cnt;
    re0 = re_cnt;

    // Edge N: handshake.
    tick();
    hs_cyc = cyc;
    chk("hs_req_ready_low", 64'(req_ready), 64'(0));
    chk("hs_no_strobe", 64'({write_enable, read_enable}), 64'(0));

    req_valid = 1'b0;
    junk      = {$urandom(), $urandom()};
    req_addr  = junk[AW-1:0];
    req_wdata = junk[63:64-WW];
    if (wr) begin
      exp_mem[idx] = wd[RW-1:0];
      last_wd      = wd;
    end

    // Edge N+1: strobe cycle.
    tick();
    chk("strobe", 64'({write_enable, read_enable}), wr ? 64'(2) : 64'(1));
    chk("address", 64'(address), 64'(addr_tab[idx]));
    chk("write_data", 64'(write_data), 64'(last_wd));
    chk("strobe_rsp_idle", 64'(rsp_valid), 64'(0));

    // Edge N+2: strobe drops and the response appears.
    tick();
    chk("strobe_drop", 64'({write_enable, read_enable}), 64'(0));
    exp_rsp = !wr || ACK;
    exp_rd  = wr ? '0 : exp_mem[idx];
    chk("rsp_valid", 64'(rsp_valid), 64'(exp_rsp));

    if (exp_rsp) begin
      chk("rsp_write", 64'(rsp_write), 64'(wr));
      chk("rsp_rdata", 64'(rsp_rdata), 64'(exp_rd));

      for (int k = 0; k < hold; k++) begin
        if (offer) begin
          req_valid = 1'b1;
          req_write = 1'($urandom_range(1, 0));
          req_addr  = addr_tab[$urandom_range(7, 0)];
        end
        tick();
        chk("hold_rsp_valid", 64'(rsp_valid), 64'(1));
        chk("hold_rsp_rdata", 64'(rsp_rdata), 64'(exp_rd));
        chk("hold_rsp_write", 64'(rsp_write), 64'(wr));
        chk("hold_req_ready", 64'(req_ready), 64'(0));
      end

      rsp_ready = 1'b1;
      // Completion edge.
      tick();
      chk("done_rsp_valid", 64'(rsp_valid), 64'(0));
      chk("done_req_ready", 64'(req_ready), 64'(1));
    end else begin
      chk("ff_req_ready", 64'(req_ready), 64'(1));
    end

    chk("we_count", 64'(we_cnt - we0), 64'(wr));
    chk("re_count", 64'(re_cnt - re0), 64'(!wr));
  endtask

  initial begin
    logic [63:0] r;

    for (int i = 0; i < 8; i++) begin
      r           = {$urandom(), $urandom()};
      addr_tab[i] = {r[AW-1:3], 3'(i)};
      exp_mem[i]  = '0;
    end
    addr_tab[2] = 33'hAA;
    last_wd     = '0;

    // Reset held for two edges, then released.
    reset = 1'b0;
    tick();
    tick();
    chk("rst_req_ready", 64'(req_ready), 64'(1));
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst_rsp_write", 64'(rsp_write), 64'(0));
    chk("rst_strobes", 64'({write_enable, read_enable}), 64'(0));
    chk("rst_address", 64'(address), 64'(0));
    chk("rst_write_data", 64'(write_data), 64'(0));
    chk("rst_rsp_rdata", 64'(rsp_rdata), 64'(0));
    reset = 1'b1;
    tick();
    chk("post_rst_req_ready", 64'(req_ready), 64'(1));
    chk("post_rst_rsp_valid", 64'(rsp_valid), 64'(0));

    // Write, then read back, the same register.
    do_txn(1'b1, 2, 33'h1234, 0, 1'b0);
    do_txn(1'b0, 2, 33'h0, 0, 1'b0);

    // Read with rsp_ready low for 5 cycles while a second request waits.
    do_txn(1'b0, 2, 33'h0, 5, 1'b1);
    prev_hs = hs_cyc;
    do_txn(1'b0, 3, 33'h0, 0, 1'b0);
    chk("held_next_accept", 64'(hs_cyc - prev_hs), 64'(4 + 5));

    // Back-to-back reads: handshakes four edges apart.
    prev_hs = hs_cyc;
    do_txn(1'b0, 2, 33'h0, 0, 1'b0);
    chk("b2b_spacing", 64'(hs_cyc - prev_hs), 64'(4));

    // Reset asserted during the strobe cycle of a read.
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = addr_tab[5];
    tick();
    req_valid = 1'b0;
    tick();
    chk("mid_rst_strobe_up", 64'(read_enable), 64'(1));
    reset = 1'b0;
    tick();
    reset = 1'b1;
    last_wd = '0;
    chk("mid_rst_strobe_drop", 64'({write_enable, read_enable}), 64'(0));
    chk("mid_rst_address", 64'(address), 64'(0));
    chk("mid_rst_req_ready", 64'(req_ready), 64'(1));
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("mid_rst_no_rsp", 64'(rsp_valid), 64'(0));
    end

    // Randomized transactions against the reference model.
    for (int t = 0; t < 40; t++) begin
      bit          wr;
      int          idx;
      int          hold;
      logic [63:0] d;

      wr   = 1'($urandom_range(1, 0));
      idx  = int'($urandom_range(7, 0));
      d    = {$urandom(), $urandom()};
      hold = ($urandom_range(2, 0) == 0) ? int'($urandom_range(4, 1)) : 0;
      do_txn(wr, idx, d[WW-1:0], hold, 1'($urandom_range(1, 0)));
    end

    // Final read-back of every register.
    for (int i = 0; i < 8; i++) begin
      do_txn(1'b0, i, 33'h0, 0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
